// File: rtl/fft_pkg.sv
// Shared constants, FSM state type and index helper for the FFT stage collector.
package fft_pkg;

  localparam int unsigned WORD_W  = 64;
  localparam int unsigned NUM_MAC = 4;
  localparam int unsigned NPTS    = NUM_MAC * 8;
  localparam int unsigned IDX_W   = 5;

  typedef enum logic {
    StCollect = 1'b0,
    StDrain   = 1'b1
  } state_e;

  function automatic logic [IDX_W-1:0] bitrev5(input logic [IDX_W-1:0] v);
    logic [IDX_W-1:0] r;
    for (int i = 0; i < int'(IDX_W); i++) begin
      r[i] = v[IDX_W-1-i];
    end
    return r;
  endfunction

endpackage

// File: rtl/fft_collect_buf.sv
// Frame buffer: NPTS result words, one write port per butterfly output, async read.
module fft_collect_buf #(
  parameter int unsigned WORD_W = 64,
  parameter int unsigned NPTS   = 32,
  parameter int unsigned NPORT  = 8,
  parameter int unsigned AW     = 5
) (
  input  logic                    clk,
  input  logic [NPORT-1:0]        wr_en,
  input  logic [NPORT*AW-1:0]     wr_addr,
  input  logic [NPORT*WORD_W-1:0] wr_data,
  input  logic [AW-1:0]           rd_addr,
  output logic [WORD_W-1:0]       rd_data
);

  // No reset: contents persist across frames and through reset.
  logic [WORD_W-1:0] mem_q [NPTS];

  always_ff @(posedge clk) begin
    for (int j = 0; j < int'(NPORT); j++) begin
      if (wr_en[j]) begin
        mem_q[wr_addr[j*AW +: AW]] <= wr_data[j*WORD_W +: WORD_W];
      end
    end
  end

  assign rd_data = mem_q[rd_addr];

endmodule

// File: rtl/fft_stage_collector.sv
// Gathers four butterfly phases into a frame buffer, then drains it one word per take.
// Define FFT_COLLECT_BITREV_EN to drain in bit-reversed address order.
module fft_stage_collector #(
  parameter int unsigned WORD_W  = fft_pkg::WORD_W,
  parameter int unsigned NUM_MAC = fft_pkg::NUM_MAC,
  parameter int unsigned NPTS    = fft_pkg::NPTS
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        in_valid,
  input  logic [1:0]                  in_phase,
  input  logic [2*NUM_MAC*WORD_W-1:0] in_data,
  output logic                        in_ready,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [WORD_W-1:0]           out_data,
  output logic [4:0]                  out_index,
  output logic                        out_last,
  output logic                        frame_done,
  output logic                        err_phase
);
  import fft_pkg::*;

  localparam int unsigned NPORT = 2 * NUM_MAC;
  localparam logic [IDX_W-1:0] LastIdx = IDX_W'(NPTS - 1);

  // Assertion is immediate; release is taken through two flops.
  logic [1:0] rst_sync_q;
  logic       rst_n;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rst_sync_q <= 2'b00;
    end else begin
      rst_sync_q <= {rst_sync_q[0], 1'b1};
    end
  end

  assign rst_n = rst_sync_q[1];

  state_e           state_q, state_d;
  logic [1:0]       phase_q, phase_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             err_q, err_d;
  logic             done_q, done_d;
  logic             beat_ok;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StCollect;
      phase_q <= 2'd0;
      idx_q   <= '0;
      err_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      idx_q   <= idx_d;
      err_q   <= err_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    phase_d   = phase_q;
    idx_d     = idx_q;
    err_d     = err_q;
    done_d    = 1'b0;
    beat_ok   = 1'b0;
    in_ready  = (state_q == StCollect);
    out_valid = (state_q == StDrain);
    unique case (state_q)
      StCollect: begin
        if (in_valid) begin
          if (in_phase == phase_q) begin
            beat_ok = 1'b1;
            phase_d = phase_q + 2'd1;
            if (phase_q == 2'd3) begin
              state_d = StDrain;
              idx_d   = '0;
            end
          end else begin
            err_d = 1'b1;
          end
        end
      end
      StDrain: begin
        if (out_ready) begin
          if (idx_q == LastIdx) begin
            state_d = StCollect;
            idx_d   = '0;
            done_d  = 1'b1;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
    endcase
  end

  // MAC m output k lands at 8m + 2p + k.
  logic [NPORT-1:0]       wr_en;
  logic [NPORT*IDX_W-1:0] wr_addr;
  logic [IDX_W-1:0]       rd_addr;

  assign wr_en = {NPORT{beat_ok & rst_n}};

  always_comb begin
    wr_addr = '0;
    for (int m = 0; m < int'(NUM_MAC); m++) begin
      for (int k = 0; k < 2; k++) begin
        wr_addr[(2*m+k)*IDX_W +: IDX_W] = IDX_W'(8 * m + 2 * int'(phase_q) + k);
      end
    end
  end

`ifdef FFT_COLLECT_BITREV_EN
  assign rd_addr = bitrev5(idx_q);
`else
  assign rd_addr = idx_q;
`endif

  fft_collect_buf #(
    .WORD_W (WORD_W),
    .NPTS   (NPTS),
    .NPORT  (NPORT),
    .AW     (IDX_W)
  ) u_buf (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (in_data),
    .rd_addr (rd_addr),
    .rd_data (out_data)
  );

  assign out_index  = rd_addr;
  assign out_last   = (state_q == StDrain) && (idx_q == LastIdx);
  assign frame_done = done_q;
  assign err_phase  = err_q;

endmodule

// File: tb/tb_fft_stage_collector.sv
// Directed bench for fft_stage_collector: collect/drain, stalls, phase errors, reset mid-drain.
module tb_fft_stage_collector;

  localparam int unsigned WORD_W  = 64;
  localparam int unsigned NUM_MAC = 4;

  logic                        clk;
  logic                        reset;
  logic                        in_valid;
  logic [1:0]                  in_phase;
  logic [2*NUM_MAC*WORD_W-1:0] in_data;
  logic                        in_ready;
  logic                        out_valid;
  logic                        out_ready;
  logic [WORD_W-1:0]           out_data;
  logic [4:0]                  out_index;
  logic                        out_last;
  logic                        frame_done;
  logic                        err_phase;

  int total = 0;
  int bad   = 0;

  fft_stage_collector #(
    .WORD_W  (WORD_W),
    .NUM_MAC (NUM_MAC),
    .NPTS    (32)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_phase   (in_phase),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_index  (out_index),
    .out_last   (out_last),
    .frame_done (frame_done),
    .err_phase  (err_phase)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [4:0] exp_addr(input int n);
    logic [4:0] v;
    v = 5'(n);
`ifdef FFT_COLLECT_BITREV_EN
    return {v[0], v[1], v[2], v[3], v[4]};
`else
    return v;
`endif
  endfunction

  // Word for buffer address a is {a, tag}.
  task automatic send_beat(input logic [1:0] ph, input logic [31:0] tag, input string name);
    in_valid = 1'b1;
    in_phase = ph;
    for (int m = 0; m < int'(NUM_MAC); m++) begin
      for (int k = 0; k < 2; k++) begin
        in_data[(2*m+k)*WORD_W +: WORD_W] = {32'(8 * m + 2 * int'(ph) + k), tag};
      end
    end
    chk({name, "_in_ready"}, 64'(in_ready), 64'd1);
    chk({name, "_no_out_valid"}, 64'(out_valid), 64'd0);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic send_frame(input logic [31:0] tag, input string name);
    for (int p = 0; p < 4; p++) begin
      send_beat(2'(p), tag, name);
    end
  endtask

  task automatic drain(input logic [31:0] tag, input bit toggle, input int stop_after,
                       input string name);
    int         n = 0;
    int         cyc = 0;
    bit         held_v = 1'b0;
    logic [63:0] held_d = '0;
    logic [4:0]  ei;
    while (n < stop_after && cyc < 200) begin
      out_ready = toggle ? (cyc % 2 == 0) : 1'b1;
      ei = exp_addr(n);
      chk({name, "_out_valid"}, 64'(out_valid), 64'd1);
      if (held_v) chk({name, "_stall_hold"}, out_data, held_d);
      chk({name, "_index"}, 64'(out_index), 64'(ei));
      chk({name, "_data"}, out_data, {27'd0, ei, tag});
      chk({name, "_last"}, 64'(out_last), 64'(n == 31));
      held_v = !out_ready;
      held_d = out_data;
      if (out_valid && out_ready) n++;
      cyc++;
      @(posedge clk);
      #1;
    end
    out_ready = 1'b0;
    chk({name, "_take_count"}, 64'(n), 64'(stop_after));
    if (stop_after == 32) begin
      chk({name, "_frame_done"}, 64'(frame_done), 64'd1);
      chk({name, "_done_out_valid"}, 64'(out_valid), 64'd0);
      chk({name, "_done_in_ready"}, 64'(in_ready), 64'd1);
    end
  endtask

  task automatic release_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
  endtask

  initial begin
    reset     = 1'b0;
    in_valid  = 1'b0;
    in_phase  = 2'd0;
    in_data   = '0;
    out_ready = 1'b0;
    #12;
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_last", 64'(out_last), 64'd0);
    chk("rst_frame_done", 64'(frame_done), 64'd0);
    chk("rst_err_phase", 64'(err_phase), 64'd0);
    release_reset();

    // Natural frame, downstream always ready.
    send_frame(32'h1, "f1");
    drain(32'h1, 1'b0, 32, "f1");
    @(posedge clk);
    #1;
    chk("f1_done_pulse_end", 64'(frame_done), 64'd0);
    chk("f1_idle_out_valid", 64'(out_valid), 64'd0);

    // Same frame shape with alternating backpressure.
    send_frame(32'h2, "f2");
    drain(32'h2, 1'b1, 32, "f2");

    // Out-of-order beat is dropped and flagged.
    send_beat(2'd0, 32'h3, "f3b0");
    chk("f3_err_before", 64'(err_phase), 64'd0);
    send_beat(2'd2, 32'hBAD, "f3bad");
    chk("f3_err_set", 64'(err_phase), 64'd1);
    send_beat(2'd1, 32'h3, "f3b1");
    send_beat(2'd2, 32'h3, "f3b2");
    send_beat(2'd3, 32'h3, "f3b3");
    drain(32'h3, 1'b0, 32, "f3");

    // Next frame starts in the frame_done cycle.
    send_frame(32'h5, "f5");
    chk("f5_err_sticky", 64'(err_phase), 64'd1);
    drain(32'h5, 1'b0, 32, "f5");

    // Reset in the middle of a drain.
    send_frame(32'h4, "f4");
    drain(32'h4, 1'b0, 17, "f4");
    chk("f4_idx17", 64'(out_index), 64'(exp_addr(17)));
    reset = 1'b0;
    #1;
    chk("mid_rst_out_valid", 64'(out_valid), 64'd0);
    chk("mid_rst_in_ready", 64'(in_ready), 64'd1);
    chk("mid_rst_out_last", 64'(out_last), 64'd0);
    chk("mid_rst_frame_done", 64'(frame_done), 64'd0);
    chk("mid_rst_err_phase", 64'(err_phase), 64'd0);
    #2;
    release_reset();
    send_frame(32'h6, "f6");
    drain(32'h6, 1'b0, 32, "f6");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
